// File: rtl/arm_alu_pkg.sv
// Shared definitions for the ARM ALU sequencer: opcodes, FSM states, NZCV bit positions
// and the opcode classification bundle.
package arm_alu_pkg;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_EOR    = 5'b00001;
  localparam logic [4:0] OP_SUB    = 5'b00010;
  localparam logic [4:0] OP_RSB    = 5'b00011;
  localparam logic [4:0] OP_ADD    = 5'b00100;
  localparam logic [4:0] OP_ADC    = 5'b00101;
  localparam logic [4:0] OP_SBC    = 5'b00110;
  localparam logic [4:0] OP_RSC    = 5'b00111;
  localparam logic [4:0] OP_TST    = 5'b01000;
  localparam logic [4:0] OP_TEQ    = 5'b01001;
  localparam logic [4:0] OP_CMP    = 5'b01010;
  localparam logic [4:0] OP_CMN    = 5'b01011;
  localparam logic [4:0] OP_ORR    = 5'b01100;
  localparam logic [4:0] OP_RSV    = 5'b01101;
  localparam logic [4:0] OP_BIC    = 5'b01110;
  localparam logic [4:0] OP_MVN    = 5'b01111;
  localparam logic [4:0] OP_BYPASS = 5'b10000;
  localparam logic [4:0] OP_INC    = 5'b10001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_EXEC,
    ST_WB
  } state_t;

  typedef struct packed {
    logic legal;
    logic uses_a;
    logic writes_rd;
    logic forces_s;
  } op_class_t;

endpackage

// File: rtl/arm_alu_op_class.sv
// Combinational opcode classifier: legality, whether operand A is read, whether Rd is
// written back, and whether flags are updated regardless of the S bit.
import arm_alu_pkg::*;

module arm_alu_op_class #(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] op,
  output op_class_t       cls
);

  logic is_compare;

  always_comb begin
    is_compare    = (op == OP_W'(OP_TST)) || (op == OP_W'(OP_TEQ)) ||
                    (op == OP_W'(OP_CMP)) || (op == OP_W'(OP_CMN));
    cls           = '0;
    // 01101 is the one hole below INC; everything above INC is unused encoding space
    cls.legal     = (op <= OP_W'(OP_INC)) && (op != OP_W'(OP_RSV));
    cls.uses_a    = !((op == OP_W'(OP_MVN)) || (op == OP_W'(OP_BYPASS)));
    cls.writes_rd = !is_compare;
    cls.forces_s  = is_compare;
  end

endmodule

// File: rtl/arm_alu_sequencer.sv
// Multi-cycle controller running one decoded data-processing instruction through the
// external ALU: operand reads, execute, write-back and NZCV update.
import arm_alu_pkg::*;

module arm_alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OP_W   = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [OP_W-1:0]   REQ_OP,
  input  logic              REQ_S,
  input  logic [REG_AW-1:0] REQ_RN,
  input  logic [REG_AW-1:0] REQ_RM,
  input  logic [REG_AW-1:0] REQ_RD,
  input  logic              REQ_IMM_SEL,
  input  logic [DATA_W-1:0] REQ_IMM,
  output logic [REG_AW-1:0] RF_RADDR,
  input  logic [DATA_W-1:0] RF_RDATA,
  output logic              RF_WE,
  output logic [REG_AW-1:0] RF_WADDR,
  output logic [DATA_W-1:0] RF_WDATA,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [OP_W-1:0]   ALU_OP,
  output logic              ALU_S,
  output logic              ALU_OUT_EN,
  output logic [3:0]        ALU_FLAGS_IN,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic [3:0]        ALU_FLAGS_OUT,
  output logic [3:0]        FLAGS,
  output logic              DONE,
  output logic              ERR
);

  state_t            state;
  state_t            state_nxt;
  op_class_t         cls;
  logic              accept;

  logic [OP_W-1:0]   op_q;
  logic              s_eff_q;
  logic              writes_rd_q;
  logic              imm_sel_q;
  logic [REG_AW-1:0] rn_q;
  logic [REG_AW-1:0] rm_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        fl_res_q;
  logic [3:0]        flags_q;
  logic              err_q;

  arm_alu_op_class #(.OP_W(OP_W)) u_class (
    .op  (REQ_OP),
    .cls (cls)
  );

  assign accept = REQ_VALID && (state == ST_IDLE);

  // Control and every register that is visible on an output port
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      flags_q <= '0;
      err_q   <= 1'b0;
      op_q    <= '0;
      s_eff_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state <= state_nxt;
      err_q <= accept && !cls.legal;
      if (accept && cls.legal) begin
        op_q    <= REQ_OP;
        s_eff_q <= REQ_S || cls.forces_s;
        if (!cls.uses_a) a_q <= '0;
        if (REQ_IMM_SEL) b_q <= REQ_IMM;
      end
      if (state == ST_RD_A) a_q <= RF_RDATA;
      if (state == ST_RD_B) b_q <= RF_RDATA;
      if ((state == ST_WB) && s_eff_q) flags_q <= fl_res_q;
    end
  end

  // Internal latches only ever consumed in a later state, so they need no reset
  always_ff @(posedge CLK) begin
    if (accept && cls.legal) begin
      writes_rd_q <= cls.writes_rd;
      imm_sel_q   <= REQ_IMM_SEL;
      rn_q        <= REQ_RN;
      rm_q        <= REQ_RM;
      rd_q        <= REQ_RD;
    end
    if (state == ST_EXEC) begin
      res_q    <= ALU_RESULT;
      fl_res_q <= ALU_FLAGS_OUT;
    end
  end

  always_comb begin
    state_nxt  = state;
    REQ_READY  = 1'b0;
    RF_RADDR   = '0;
    RF_WE      = 1'b0;
    RF_WADDR   = '0;
    RF_WDATA   = '0;
    ALU_OUT_EN = 1'b0;
    ALU_S      = 1'b0;
    DONE       = 1'b0;
    case (state)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (accept && cls.legal) begin
          if (cls.uses_a)       state_nxt = ST_RD_A;
          else if (REQ_IMM_SEL) state_nxt = ST_EXEC;
          else                  state_nxt = ST_RD_B;
        end
      end
      ST_RD_A: begin
        RF_RADDR  = rn_q;
        state_nxt = imm_sel_q ? ST_EXEC : ST_RD_B;
      end
      ST_RD_B: begin
        RF_RADDR  = rm_q;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        ALU_OUT_EN = 1'b1;
        ALU_S      = s_eff_q;
        state_nxt  = ST_WB;
      end
      ST_WB: begin
        RF_WE     = writes_rd_q;
        RF_WADDR  = writes_rd_q ? rd_q : '0;
        RF_WDATA  = writes_rd_q ? res_q : '0;
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ALU_A        = a_q;
  assign ALU_B        = b_q;
  assign ALU_OP       = op_q;
  assign ALU_FLAGS_IN = flags_q;
  assign FLAGS        = flags_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_arm_alu_sequencer.sv
// Directed bench: a register-file and ALU stand-in surround the sequencer; each instruction
// is checked against hand-computed results, latencies and flag values.
import arm_alu_pkg::*;

module tb_arm_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [4:0]  REQ_OP;
  logic        REQ_S;
  logic [3:0]  REQ_RN, REQ_RM, REQ_RD;
  logic        REQ_IMM_SEL;
  logic [31:0] REQ_IMM;
  logic [3:0]  RF_RADDR;
  logic [31:0] RF_RDATA;
  logic        RF_WE;
  logic [3:0]  RF_WADDR;
  logic [31:0] RF_WDATA;
  logic [31:0] ALU_A, ALU_B;
  logic [4:0]  ALU_OP;
  logic        ALU_S, ALU_OUT_EN;
  logic [3:0]  ALU_FLAGS_IN;
  logic [31:0] ALU_RESULT;
  logic [3:0]  ALU_FLAGS_OUT;
  logic [3:0]  FLAGS;
  logic        DONE, ERR;

  arm_alu_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP), .REQ_S(REQ_S),
    .REQ_RN(REQ_RN), .REQ_RM(REQ_RM), .REQ_RD(REQ_RD),
    .REQ_IMM_SEL(REQ_IMM_SEL), .REQ_IMM(REQ_IMM),
    .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_S(ALU_S),
    .ALU_OUT_EN(ALU_OUT_EN), .ALU_FLAGS_IN(ALU_FLAGS_IN),
    .ALU_RESULT(ALU_RESULT), .ALU_FLAGS_OUT(ALU_FLAGS_OUT),
    .FLAGS(FLAGS), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Register file stand-in: preset contents loaded while reset is held
  logic [31:0] rf [16];
  always @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      rf[1]  <= 32'd5;
      rf[2]  <= 32'd7;
      rf[4]  <= 32'd3;
      rf[5]  <= 32'd3;
      rf[7]  <= 32'hFFFF_FFFF;
      rf[8]  <= 32'd2;
      rf[10] <= 32'd1;
      rf[11] <= 32'd1;
    end else if (RF_WE) begin
      rf[RF_WADDR] <= RF_WDATA;
    end
  end
  assign RF_RDATA = rf[RF_RADDR];

  // ALU stand-in; subtraction reports C as borrow
  logic [32:0] sum;
  logic [31:0] r;
  logic        c, v;
  always_comb begin
    sum = '0;
    r   = '0;
    c   = ALU_FLAGS_IN[FLAG_C];
    v   = ALU_FLAGS_IN[FLAG_V];
    case (ALU_OP)
      OP_AND, OP_TST: r = ALU_A & ALU_B;
      OP_EOR, OP_TEQ: r = ALU_A ^ ALU_B;
      OP_ORR:         r = ALU_A | ALU_B;
      OP_BIC:         r = ALU_A & ~ALU_B;
      OP_ADD, OP_CMN, OP_ADC: begin
        sum = {1'b0, ALU_A} + {1'b0, ALU_B} +
              ((ALU_OP == OP_ADC) ? {32'd0, ALU_FLAGS_IN[FLAG_C]} : 33'd0);
        r = sum[31:0];
        c = sum[32];
        v = (ALU_A[31] == ALU_B[31]) && (r[31] != ALU_A[31]);
      end
      OP_SUB, OP_CMP: begin
        r = ALU_A - ALU_B;
        c = (ALU_A < ALU_B);
        v = (ALU_A[31] != ALU_B[31]) && (r[31] != ALU_A[31]);
      end
      OP_MVN:    r = ~ALU_B;
      OP_BYPASS: r = ALU_B;
      OP_INC:    r = ALU_A + 32'd1;
      default:   r = ALU_A;
    endcase
    ALU_RESULT            = r;
    ALU_FLAGS_OUT         = '0;
    ALU_FLAGS_OUT[FLAG_N] = r[31];
    ALU_FLAGS_OUT[FLAG_Z] = (r == 32'd0);
    ALU_FLAGS_OUT[FLAG_C] = c;
    ALU_FLAGS_OUT[FLAG_V] = v;
  end

  // Event monitor, sampled on the falling edge
  int          cyc = 0, acc_cnt = 0, acc_cyc = 0, acc_gap = 0;
  int          done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int          we_cnt = 0, raddr_nz = 0;
  logic        err_ready = 1'b0, exec_cin = 1'b0, exec_s = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  always @(negedge CLK) begin
    cyc++;
    if (REQ_VALID && REQ_READY) begin
      acc_cnt++;
      acc_gap = cyc - done_cyc;
      acc_cyc = cyc;
    end
    if (DONE) begin done_cnt++; done_cyc = cyc; end
    if (ERR) begin err_cnt++; err_cyc = cyc; err_ready = REQ_READY; end
    if (RF_WE) begin we_cnt++; w_addr = RF_WADDR; w_data = RF_WDATA; end
    if (RF_RADDR != 4'd0) raddr_nz++;
    if (ALU_OUT_EN) begin exec_cin = ALU_FLAGS_IN[FLAG_C]; exec_s = ALU_S; end
  end

  int n_cmp = 0, n_bad = 0;
  int we0, done0, err0, rnz0, acc0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic s, input logic [3:0] rn,
                       input logic [3:0] rm, input logic [3:0] rd,
                       input logic isel, input logic [31:0] imm);
    int n;
    @(posedge CLK); #1;
    REQ_OP = op; REQ_S = s; REQ_RN = rn; REQ_RM = rm; REQ_RD = rd;
    REQ_IMM_SEL = isel; REQ_IMM = imm; REQ_VALID = 1'b1;
    we0 = we_cnt; done0 = done_cnt; err0 = err_cnt; rnz0 = raddr_nz;
    n = 0;
    while (!REQ_READY && n < 30) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    n = 0;
    while (done_cnt == done0 && err_cnt == err0 && n < 20) begin @(posedge CLK); #1; n++; end
    if (n >= 20) chk("completion_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_OP = '0; REQ_S = 1'b0;
    REQ_RN = '0; REQ_RM = '0; REQ_RD = '0; REQ_IMM_SEL = 1'b0; REQ_IMM = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready",  32'(REQ_READY),  32'd1);
    chk("rst_flags",  32'(FLAGS),      32'd0);
    chk("rst_done",   32'(DONE),       32'd0);
    chk("rst_err",    32'(ERR),        32'd0);
    chk("rst_we",     32'(RF_WE),      32'd0);
    chk("rst_out_en", 32'(ALU_OUT_EN), 32'd0);
    chk("rst_alu_a",  ALU_A,           32'd0);
    RESET_N = 1'b1;

    // ADDS R7+R8 = FFFFFFFF+2 -> 1 with carry out
    issue(OP_ADD, 1'b1, 4'd7, 4'd8, 4'd9, 1'b0, 32'd0);
    chk("adds_wdata", w_data, 32'd1);
    chk("adds_flags", 32'(FLAGS), 32'b0010);

    // ADC 1+1 with C=1, S=0
    issue(OP_ADC, 1'b0, 4'd10, 4'd11, 4'd12, 1'b0, 32'd0);
    chk("adc_cin",   32'(exec_cin), 32'd1);
    chk("adc_wdata", w_data, 32'd3);
    chk("adc_flags", 32'(FLAGS), 32'b0010);

    // CMP 3,3 with S=0: flags still updated, no write-back
    issue(OP_CMP, 1'b0, 4'd4, 4'd5, 4'd6, 1'b0, 32'd0);
    chk("cmp_flags", 32'(FLAGS), 32'b0100);
    chk("cmp_alu_s", 32'(exec_s), 32'd1);
    chk("cmp_no_we", 32'(we_cnt - we0), 32'd0);
    chk("cmp_done",  32'(done_cnt - done0), 32'd1);

    // SUBS 3-3
    issue(OP_SUB, 1'b1, 4'd4, 4'd5, 4'd6, 1'b0, 32'd0);
    chk("subs_wdata", w_data, 32'd0);
    chk("subs_waddr", 32'(w_addr), 32'd6);
    chk("subs_flags", 32'(FLAGS), 32'b0100);

    // ADD R1+R2 -> R3, S=0, full four-cycle path
    issue(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
    chk("add_wdata",   w_data, 32'd12);
    chk("add_waddr",   32'(w_addr), 32'd3);
    chk("add_we_once", 32'(we_cnt - we0), 32'd1);
    chk("add_done",    32'(done_cnt - done0), 32'd1);
    chk("add_latency", 32'(done_cyc - acc_cyc), 32'd4);
    chk("add_flags",   32'(FLAGS), 32'b0100);

    // ADD immediate: RM read skipped
    issue(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd14, 1'b1, 32'd10);
    chk("addi_wdata",   w_data, 32'd15);
    chk("addi_latency", 32'(done_cyc - acc_cyc), 32'd3);

    // MVN immediate 0: both reads skipped
    issue(OP_MVN, 1'b0, 4'd5, 4'd6, 4'd13, 1'b1, 32'd0);
    chk("mvn_wdata",   w_data, 32'hFFFF_FFFF);
    chk("mvn_waddr",   32'(w_addr), 32'd13);
    chk("mvn_latency", 32'(done_cyc - acc_cyc), 32'd2);
    chk("mvn_no_read", 32'(raddr_nz - rnz0), 32'd0);

    // Illegal opcodes
    issue(OP_RSV, 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
    chk("ill_err",     32'(err_cnt - err0), 32'd1);
    chk("ill_err_lat", 32'(err_cyc - acc_cyc), 32'd1);
    chk("ill_ready",   32'(err_ready), 32'd1);
    chk("ill_no_we",   32'(we_cnt - we0), 32'd0);
    chk("ill_no_done", 32'(done_cnt - done0), 32'd0);
    chk("ill_flags",   32'(FLAGS), 32'b0100);
    issue(5'b10010, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
    chk("ill2_err",    32'(err_cnt - err0), 32'd1);

    // Reset while in EXEC of an ADDS
    @(posedge CLK); #1;
    REQ_OP = OP_ADD; REQ_S = 1'b1; REQ_RN = 4'd7; REQ_RM = 4'd8; REQ_RD = 4'd15;
    REQ_IMM_SEL = 1'b0; REQ_VALID = 1'b1;
    we0 = we_cnt; done0 = done_cnt;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    n = 0;
    while (!ALU_OUT_EN && n < 10) begin @(posedge CLK); #1; n++; end
    chk("rx_exec_reached", 32'(ALU_OUT_EN), 32'd1);
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    chk("rx_ready",  32'(REQ_READY), 32'd1);
    chk("rx_out_en", 32'(ALU_OUT_EN), 32'd0);
    chk("rx_flags",  32'(FLAGS), 32'd0);
    RESET_N = 1'b1;
    repeat (4) begin @(posedge CLK); #1; end
    chk("rx_no_we",   32'(we_cnt - we0), 32'd0);
    chk("rx_no_done", 32'(done_cnt - done0), 32'd0);
    chk("rx_flags2",  32'(FLAGS), 32'd0);

    // VALID held across a busy instruction: second accept only the cycle after WB
    @(posedge CLK); #1;
    REQ_OP = OP_ADD; REQ_S = 1'b0; REQ_RN = 4'd1; REQ_RM = 4'd2; REQ_RD = 4'd3;
    REQ_IMM_SEL = 1'b0; REQ_VALID = 1'b1;
    acc0 = acc_cnt; we0 = we_cnt; done0 = done_cnt;
    n = 0;
    while (acc_cnt < acc0 + 2 && n < 30) begin @(posedge CLK); #1; n++; end
    REQ_VALID = 1'b0;
    chk("held_accepts", 32'(acc_cnt - acc0), 32'd2);
    chk("held_gap",     32'(acc_gap), 32'd1);
    n = 0;
    while (done_cnt < done0 + 2 && n < 30) begin @(posedge CLK); #1; n++; end
    chk("held_done",  32'(done_cnt - done0), 32'd2);
    chk("held_we",    32'(we_cnt - we0), 32'd2);
    chk("held_wdata", w_data, 32'd12);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
